// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: valid/ready load/store requests answered
// after WAIT_CYCLES wait states, with byte-lane stores and misaligned/out-of-range errors.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] idx_q;

  logic [31:0]           mem [2**ADDR_WIDTH];

  logic                  accept;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] acc_idx;

  assign accept  = (state == IDLE) && req_valid;
  assign acc_idx = req_addr[ADDR_WIDTH+1:2];
  assign acc_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != '0);

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Storage is never reset; stores commit on the accept edge so a store survives
  // a reset that arrives while its response is still pending.
  always_ff @(posedge clk) begin
    if (reset && accept && req_we && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          mem[acc_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            err_q <= acc_err;
            idx_q <= acc_idx;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_err   <= acc_err;
              rsp_rdata <= (req_we || acc_err) ? '0 : mem[acc_idx];
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_err   <= err_q;
            rsp_rdata <= (we_q || err_q) ? '0 : mem[idx_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
